vga_cell_scanner: RTL and testbench

- Drives the 640x480@60 VGA raster and maps each visible pixel to a 128x96 life-grid cell, 5x5 pixels per cell.
- Issues the cell's grid-memory read address and presents x_index/y_index to the downstream colour generator (hue from x, saturation from y).
- Merges cell_alive with the returned colour into a registered RGB332 pixel, plus syncs.
- Also emits a once-per-frame vblank pulse that the life engine uses to step a generation.

---
 rtl/vga_cell_scanner.sv | 154 +++++++++++++++
 tb/tb_vga_cell_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_cell_scanner.sv
// vga_cell_scanner
// Generates the 640x480@60 VGA raster from a divided system clock and maps
// each visible pixel onto a cell of the life grid (CELL_PX x CELL_PX pixels
// per cell). The current cell's memory address and column/row indices are
// presented combinationally from registers; the returned cell_alive bit and
// colour are merged into a registered RGB332 pixel alongside the syncs.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   cell_alive  grid-memory read data (1 clk latency after grid_addr)
//   color       RGB332 from the colour generator (combinational on indices)
//   grid_addr   {y_index[6:0], x_index[6:0]}
//   x_index     current cell column
//   y_index     current cell row
//   hsync       active-low horizontal sync, registered
//   vsync       active-low vertical sync, registered
//   rgb         registered RGB332 pixel
//   frame_tick  one-clk pulse at the start of vertical blank
//
// The raster geometry is parameterised; the defaults give standard 640x480.
module vga_cell_scanner #(
    parameter int         CLK_DIV    = 4,
    parameter int         CELL_PX    = 5,
    parameter logic [7:0] DEAD_COLOR = 8'h00,
    parameter int         H_VIS      = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_VIS      = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cell_alive,
    input  logic [7:0]  color,
    output logic [13:0] grid_addr,
    output logic [7:0]  x_index,
    output logic [7:0]  y_index,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  rgb,
    output logic        frame_tick
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SS  = H_VIS + H_FP;
    localparam int H_SE  = H_SS + H_SYNC - 1;
    localparam int V_SS  = V_VIS + V_FP;
    localparam int V_SE  = V_SS + V_SYNC - 1;
    localparam int DW    = $clog2(CLK_DIV);
    localparam int SW    = (CELL_PX > 2) ? $clog2(CELL_PX) : 1;

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt, v_cnt;
    logic [SW-1:0] sub_x, sub_y;

    logic          pix_tick;
    logic          h_last, v_last, h_vis, v_vis;
    logic [9:0]    h_nxt, v_nxt;
    logic [SW-1:0] sub_x_nxt, sub_y_nxt;
    logic [7:0]    x_nxt, y_nxt;
    logic [7:0]    rgb_nxt;
    logic          hsync_nxt, vsync_nxt;

    assign pix_tick  = (div_cnt == DW'(CLK_DIV - 1));
    assign h_last    = (h_cnt == 10'(H_TOT - 1));
    assign v_last    = (v_cnt == 10'(V_TOT - 1));
    assign h_vis     = (h_cnt < 10'(H_VIS));
    assign v_vis     = (v_cnt < 10'(V_VIS));
    assign grid_addr = {y_index[6:0], x_index[6:0]};

    // Raster counters and cell indices. Cells are tracked with sub-cell
    // counters so no divider is needed; indices sit at 0 through blanking
    // so the first visible pixel of each line/frame starts on cell 0.
    always_comb begin
        h_nxt     = h_last ? 10'd0 : h_cnt + 10'd1;
        v_nxt     = v_cnt;
        sub_x_nxt = sub_x;
        x_nxt     = x_index;
        sub_y_nxt = sub_y;
        y_nxt     = y_index;

        if (!h_vis || h_cnt == 10'(H_VIS - 1)) begin
            sub_x_nxt = '0;
            x_nxt     = 8'd0;
        end else if (sub_x == SW'(CELL_PX - 1)) begin
            sub_x_nxt = '0;
            x_nxt     = x_index + 8'd1;
        end else begin
            sub_x_nxt = sub_x + SW'(1);
        end

        if (h_last) begin
            v_nxt = v_last ? 10'd0 : v_cnt + 10'd1;
            // v wrap (524->0) lands here too, so rows are already 0 for line 0
            if (!v_vis || v_cnt == 10'(V_VIS - 1)) begin
                sub_y_nxt = '0;
                y_nxt     = 8'd0;
            end else if (sub_y == SW'(CELL_PX - 1)) begin
                sub_y_nxt = '0;
                y_nxt     = y_index + 8'd1;
            end else begin
                sub_y_nxt = sub_y + SW'(1);
            end
        end
    end

    // Pixel for the current raster position; cell_alive/color belong to the
    // index registers that have been stable since the previous pix_tick.
    always_comb begin
        rgb_nxt = 8'h00;
        if (h_vis && v_vis)
            rgb_nxt = cell_alive ? color : DEAD_COLOR;
        hsync_nxt = ~((h_cnt >= 10'(H_SS)) && (h_cnt <= 10'(H_SE)));
        vsync_nxt = ~((v_cnt >= 10'(V_SS)) && (v_cnt <= 10'(V_SE)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            h_cnt      <= 10'd0;
            v_cnt      <= 10'd0;
            sub_x      <= '0;
            sub_y      <= '0;
            x_index    <= 8'd0;
            y_index    <= 8'd0;
            rgb        <= 8'h00;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            // registered off the pix_tick that leaves the last visible line
            frame_tick <= pix_tick && h_last && (v_cnt == 10'(V_VIS - 1));
            if (pix_tick) begin
                div_cnt <= '0;
                rgb     <= rgb_nxt;
                hsync   <= hsync_nxt;
                vsync   <= vsync_nxt;
                h_cnt   <= h_nxt;
                v_cnt   <= v_nxt;
                sub_x   <= sub_x_nxt;
                sub_y   <= sub_y_nxt;
                x_index <= x_nxt;
                y_index <= y_nxt;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_cell_scanner.sv
// Bench for vga_cell_scanner. Three instances share clk/rst:
//   0: CLK_DIV=4, full 640x480 geometry, only cell (3,2) alive, colour E0
//   1: CLK_DIV=2, full geometry, cell (3,2) + column 0 alive, index colour
//   2: CLK_DIV=2, reduced geometry (40x30 visible, 56x37 total) so whole
//      frames fit: vsync, row wrap, frame_tick
module tb_vga_cell_scanner;

    logic clk, rst;

    logic        al0, al1, al2;
    logic [7:0]  co0, co1, co2;
    logic [13:0] ad0, ad1, ad2;
    logic [7:0]  xi0, xi1, xi2, yi0, yi1, yi2, rg0, rg1, rg2;
    logic        hs0, hs1, hs2, vs0, vs1, vs2, ft0, ft1, ft2;

    vga_cell_scanner #(.CLK_DIV(4)) u0 (
        .clk(clk), .rst(rst), .cell_alive(al0), .color(co0), .grid_addr(ad0),
        .x_index(xi0), .y_index(yi0), .hsync(hs0), .vsync(vs0), .rgb(rg0),
        .frame_tick(ft0));
    vga_cell_scanner #(.CLK_DIV(2)) u1 (
        .clk(clk), .rst(rst), .cell_alive(al1), .color(co1), .grid_addr(ad1),
        .x_index(xi1), .y_index(yi1), .hsync(hs1), .vsync(vs1), .rgb(rg1),
        .frame_tick(ft1));
    vga_cell_scanner #(.CLK_DIV(2), .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
                       .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(3)) u2 (
        .clk(clk), .rst(rst), .cell_alive(al2), .color(co2), .grid_addr(ad2),
        .x_index(xi2), .y_index(yi2), .hsync(hs2), .vsync(vs2), .rgb(rg2),
        .frame_tick(ft2));

    // grid memory models, 1 clk read latency
    always @(posedge clk) begin
        al0 <= (ad0 == 14'h103);
        al1 <= (ad1 == 14'h103) || (ad1[6:0] == 7'd0);
        al2 <= (ad2 == 14'h287) || (ad2[6:0] == 7'd0);
    end
    assign co0 = 8'hE0;
    assign co1 = {xi1[2:0], yi1[4:0]} ^ 8'h5A;
    assign co2 = {xi2[2:0], yi2[4:0]} ^ 8'h5A;

    // per-instance geometry for the reference model
    int cdv[3] = '{4, 2, 2};
    int htv[3] = '{800, 800, 56};
    int vtv[3] = '{525, 525, 37};
    int hvv[3] = '{640, 640, 40};
    int vvv[3] = '{480, 480, 30};
    int hss[3] = '{656, 656, 44};
    int hse[3] = '{751, 751, 51};
    int vss[3] = '{490, 490, 32};
    int vse[3] = '{491, 491, 33};
    int axv[3] = '{3, 3, 7};
    int ayv[3] = '{2, 2, 5};
    int c0v[3] = '{0, 1, 1};
    int ecv[3] = '{0, 1, 1};

    int checks = 0;
    int errors = 0;
    int unsigned cyc;      // clk edges since reset release
    int unsigned ft_q[$];  // cyc values where instance 2 frame_tick is high
    int ft_other = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ft2 && !rst) ft_q.push_back(cyc);
        if (ft0 || ft1 || (rst && ft2)) ft_other++;
    end

    typedef struct {
        int          sel;
        int          h;
        int          v;
        logic [7:0]  xi;
        logic [7:0]  yi;
        logic [13:0] ad;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // advance to 1 time unit after clk edge number t (since reset release)
    task automatic goto(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int s, output logic [7:0] r, output logic hs,
                          output logic vs, output logic [7:0] xi,
                          output logic [7:0] yi, output logic [13:0] ad);
        case (s)
            0: begin r = rg0; hs = hs0; vs = vs0; xi = xi0; yi = yi0; ad = ad0; end
            1: begin r = rg1; hs = hs1; vs = vs1; xi = xi1; yi = yi1; ad = ad1; end
            default: begin r = rg2; hs = hs2; vs = vs2; xi = xi2; yi = yi2; ad = ad2; end
        endcase
    endtask

    function automatic logic [7:0] exp_px(input int s, input int h, input int v);
        int cx, cy;
        logic [7:0] c;
        if (h >= hvv[s] || v >= vvv[s]) return 8'h00;
        cx = h / 5;
        cy = v / 5;
        if (!((cx == axv[s] && cy == ayv[s]) || (c0v[s] != 0 && cx == 0)))
            return 8'h00;
        c = {cx[2:0], cy[4:0]} ^ 8'h5A;
        return (ecv[s] != 0) ? c : 8'hE0;
    endfunction

    // compare every output pixel of the first npix pixels against the model
    task automatic run_stream(input int s, input int npix);
        int bad_r, bad_h, bad_v, fr, fh, fv, low0, h, v;
        logic [7:0] r, xi, yi, er;
        logic hs, vs, ehs, evs;
        logic [13:0] ad;
        bad_r = 0; bad_h = 0; bad_v = 0; fr = -1; fh = -1; fv = -1; low0 = 0;
        for (int p = 0; p < npix; p++) begin
            goto(cdv[s] * (p + 1));
            h = p % htv[s];
            v = (p / htv[s]) % vtv[s];
            sample(s, r, hs, vs, xi, yi, ad);
            er  = exp_px(s, h, v);
            ehs = !(h >= hss[s] && h <= hse[s]);
            evs = !(v >= vss[s] && v <= vse[s]);
            if (r !== er)   begin bad_r++; if (fr < 0) fr = p; end
            if (hs !== ehs) begin bad_h++; if (fh < 0) fh = p; end
            if (vs !== evs) begin bad_v++; if (fv < 0) fv = p; end
            if (p < htv[s] && hs === 1'b0) low0++;
        end
        chk($sformatf("u%0d_rgb_stream(first bad px %0d)", s, fr), bad_r, 0);
        chk($sformatf("u%0d_hsync_stream(first bad px %0d)", s, fh), bad_h, 0);
        chk($sformatf("u%0d_vsync_stream(first bad px %0d)", s, fv), bad_v, 0);
        chk($sformatf("u%0d_hsync_low_line0", s), low0, hse[s] - hss[s] + 1);
    endtask

    task automatic run_table(input int s);
        logic [7:0] r, xi, yi;
        logic hs, vs;
        logic [13:0] ad;
        int p;
        foreach (vecs[i]) begin
            if (vecs[i].sel == s) begin
                p = vecs[i].v * htv[s] + vecs[i].h;
                goto(cdv[s] * p);
                sample(s, r, hs, vs, xi, yi, ad);
                chk($sformatf("u%0d_x_index@(%0d,%0d)", s, vecs[i].h, vecs[i].v), xi, vecs[i].xi);
                chk($sformatf("u%0d_y_index@(%0d,%0d)", s, vecs[i].h, vecs[i].v), yi, vecs[i].yi);
                chk($sformatf("u%0d_grid_addr@(%0d,%0d)", s, vecs[i].h, vecs[i].v), ad, vecs[i].ad);
            end
        end
    endtask

    task automatic add(input int s, input int h, input int v, input int xi,
                       input int yi, input int ad);
        vec_t e;
        e.sel = s; e.h = h; e.v = v;
        e.xi = 8'(xi); e.yi = 8'(yi); e.ad = 14'(ad);
        vecs.push_back(e);
    endtask

    initial begin
        logic found;
        int unsigned at;
        int unsigned ft_exp[3];
        ft_exp = '{3360, 7504, 11648};

        // {instance, h, v(absolute line), x_index, y_index, grid_addr}
        add(0,   0,  0,   0, 0, 'h000); add(0,   4,  0,   0, 0, 'h000);
        add(0,   5,  0,   1, 0, 'h001); add(0,   9,  0,   1, 0, 'h001);
        add(0,  10,  0,   2, 0, 'h002); add(0, 639,  0, 127, 0, 'h07F);
        add(0, 640,  0,   0, 0, 'h000); add(0, 799,  0,   0, 0, 'h000);
        add(0,   0,  4,   0, 0, 'h000); add(0,   0,  5,   0, 1, 'h080);
        add(0,  15, 10,   3, 2, 'h103); add(0,  19, 14,   3, 2, 'h103);
        add(0,  20, 14,   4, 2, 'h104); add(0, 300, 14,  60, 2, 'h13C);
        add(1,   4,  1,   0, 0, 'h000); add(1,   5,  1,   1, 0, 'h001);
        add(1, 639,  3, 127, 0, 'h07F); add(1, 640,  3,   0, 0, 'h000);
        add(1, 799,  9,   0, 1, 'h080); add(1,   0, 10,   0, 2, 'h100);
        add(1,  15, 10,   3, 2, 'h103);
        add(2,  39,  0,   7, 0, 'h007); add(2,  40,  0,   0, 0, 'h000);
        add(2,   0, 29,   0, 5, 'h280); add(2,  39, 29,   7, 5, 'h287);
        add(2,  40, 29,   0, 5, 'h280); add(2,  55, 29,   0, 5, 'h280);
        add(2,   0, 30,   0, 0, 'h000); add(2,  55, 36,   0, 0, 'h000);
        add(2,   0, 37,   0, 0, 'h000); add(2,  10, 42,   2, 1, 'h082);

        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_rgb", rg0, 0);
        chk("reset_hsync", hs0, 1);
        chk("reset_vsync", vs0, 1);
        chk("reset_frame_tick", ft0 | ft1 | ft2, 0);
        chk("reset_x_index", xi0, 0);
        chk("reset_y_index", yi0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        fork
            run_stream(0, 16 * 800);
            run_stream(1, 16 * 800);
            begin
                run_stream(2, 3 * 56 * 37);
                chk("frame_tick_pulses", ft_q.size(), 3);
                for (int i = 0; i < 3; i++)
                    if (ft_q.size() > i)
                        chk($sformatf("frame_tick_cyc%0d", i), ft_q[i], ft_exp[i]);
            end
            run_table(0);
            run_table(1);
            run_table(2);
        join
        chk("frame_tick_spurious", ft_other, 0);

        // mid-line reset on instance 0 at h=300 of line 17
        goto(4 * (17 * 800 + 300));
        chk("pre_reset_x_index", xi0, 60);
        #2 rst = 1'b1;
        #1;
        chk("midreset_rgb", rg0, 0);
        chk("midreset_hsync", hs0, 1);
        chk("midreset_vsync", vs0, 1);
        chk("midreset_x_index", xi0, 0);
        chk("midreset_y_index", yi0, 0);
        chk("midreset_grid_addr", ad0, 0);
        @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        at = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (hs0 === 1'b0) begin
                found = 1'b1;
                at = cyc;
            end
        end
        chk("post_reset_hsync_seen", found, 1);
        chk("post_reset_hsync_clks", at, 657 * 4);
        chk("frame_tick_after_reset", ft_other, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
